// File: rtl/dmem_arbiter_if.sv
// Requester-side bus shared by the core and debug ports of dmem_arbiter.
// The master modport is the requester; the slave modport is the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              stall;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, stall, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, stall, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read DMEM between the core load/store path and a
// debug/DMA master: 0-cycle grant, registered response one cycle later.
//
// last      | meaning
// ----------+------------------------------------------------
// LAST_IDLE | nobody was granted in the previous cycle
// LAST_CORE | core owned the memory in the previous cycle
// LAST_DBG  | debug owned the memory in the previous cycle
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     core_if,
    dmem_arbiter_if.slave     dbg_if,
    input  logic              dbg_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_MemRW,
    input  logic [31:0]       mem_rdata
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

    localparam logic [1:0] LAST_IDLE = 2'd0;
    localparam logic [1:0] LAST_CORE = 2'd1;
    localparam logic [1:0] LAST_DBG  = 2'd2;

    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             core_rvalid_q, core_rvalid_d;
    logic [31:0]      core_rdata_q, core_rdata_d;
    logic             core_err_q, core_err_d;
    logic             dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]      dbg_rdata_q, dbg_rdata_d;
    logic             dbg_err_q, dbg_err_d;

    logic              core_gnt, dbg_gnt;
    logic              sel_we, aligned;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata, load_data;

    // rst_n is active-high despite its name; grants are suppressed while it is set.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst_n) begin
            if (core_if.req && !dbg_if.req) begin
                core_gnt = 1'b1;
            end else if (!core_if.req && dbg_if.req) begin
                dbg_gnt = 1'b1;
            end else if (core_if.req && dbg_if.req) begin
                if (wait_cnt_q == WAIT_SAT) begin
                    core_gnt = 1'b1;
                end else if (dbg_lock && (last_q == LAST_DBG)) begin
                    dbg_gnt = 1'b1;
                end else if (last_q == LAST_CORE) begin
                    dbg_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (core_gnt) begin
            sel_we    = core_if.we;
            sel_addr  = core_if.addr;
            sel_wdata = core_if.wdata;
        end else if (dbg_gnt) begin
            sel_we    = dbg_if.we;
            sel_addr  = dbg_if.addr;
            sel_wdata = dbg_if.wdata;
        end
        aligned   = (sel_addr[1:0] == 2'b00);
        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
        // Misaligned stores are accepted and flagged, but never reach the array.
        mem_MemRW = sel_we & aligned;
        load_data = (!sel_we && aligned) ? mem_rdata : 32'h0;
    end

    always_comb begin
        last_d = LAST_IDLE;
        if (core_gnt) begin
            last_d = LAST_CORE;
        end else if (dbg_gnt) begin
            last_d = LAST_DBG;
        end

        wait_cnt_d = '0;
        if (core_if.req && !core_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end

        core_rvalid_d = core_gnt;
        core_rdata_d  = core_gnt ? load_data : 32'h0;
        core_err_d    = core_gnt & ~aligned;
        dbg_rvalid_d  = dbg_gnt;
        dbg_rdata_d   = dbg_gnt ? load_data : 32'h0;
        dbg_err_d     = dbg_gnt & ~aligned;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_q        <= LAST_DBG;
            wait_cnt_q    <= '0;
            core_rvalid_q <= 1'b0;
            core_rdata_q  <= 32'h0;
            core_err_q    <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            dbg_rdata_q   <= 32'h0;
            dbg_err_q     <= 1'b0;
        end else begin
            last_q        <= last_d;
            wait_cnt_q    <= wait_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            core_err_q    <= core_err_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            dbg_rdata_q   <= dbg_rdata_d;
            dbg_err_q     <= dbg_err_d;
        end
    end

    assign core_if.gnt    = core_gnt;
    assign core_if.stall  = core_if.req & ~core_gnt;
    assign core_if.rvalid = core_rvalid_q;
    assign core_if.rdata  = core_rdata_q;
    assign core_if.err    = core_err_q;

    assign dbg_if.gnt     = dbg_gnt;
    assign dbg_if.stall   = dbg_if.req & ~dbg_gnt;
    assign dbg_if.rvalid  = dbg_rvalid_q;
    assign dbg_if.rdata   = dbg_rdata_q;
    assign dbg_if.err     = dbg_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level reference model and a shadow memory.
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        dbg_lock;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_MemRW;
    logic [31:0] mem_rdata;

    dmem_arbiter_if #(.ADDR_W(32)) core_if ();
    dmem_arbiter_if #(.ADDR_W(32)) dbg_if ();

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core_if   (core_if),
        .dbg_if    (dbg_if),
        .dbg_lock  (dbg_lock),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_MemRW (mem_MemRW),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    // DMEM seen by the DUT (written only by the DUT) and the model's shadow copy.
    logic [31:0] dmem    [64] = '{default: 32'h0};
    logic [31:0] ref_mem [64] = '{default: 32'h0};

    always @(posedge clk) if (mem_MemRW) dmem[idx(mem_addr)] <= mem_wdata;
    assign mem_rdata = dmem[idx(mem_addr)];

    int n_tests = 0;
    int n_fail  = 0;
    int owner   = 2;   // 0 none, 1 core, 2 debug: who held the memory last cycle
    int starve  = 0;   // consecutive cycles the core asked and was refused
    int last_g  = 0;

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic cr, input logic dr);
        if (rst_n) return 0;
        if (!cr && !dr) return 0;
        if (cr && !dr) return 1;
        if (dr && !cr) return 2;
        if (starve >= MAX_WAIT) return 1;
        if (dbg_lock && owner == 2) return 2;
        return (owner == 1) ? 2 : 1;
    endfunction

    task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_if.req = r; core_if.we = w; core_if.addr = a; core_if.wdata = d;
    endtask

    task automatic set_dbg(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        dbg_if.req = r; dbg_if.we = w; dbg_if.addr = a; dbg_if.wdata = d;
    endtask

    // One clock cycle: check combinational outputs, advance model, check responses.
    task automatic step();
        int          g;
        logic        cr, dr, w, al, in_rst;
        logic [31:0] a, wd, exp_rd;
        #1;
        cr = core_if.req; dr = dbg_if.req; in_rst = rst_n;
        g = pick(cr, dr);
        w = 1'b0; a = 32'h0; wd = 32'h0;
        if (g == 1) begin
            w = core_if.we; a = core_if.addr; wd = core_if.wdata;
        end else if (g == 2) begin
            w = dbg_if.we; a = dbg_if.addr; wd = dbg_if.wdata;
        end
        al = (a[1:0] == 2'b00);
        check_b("core_gnt", core_if.gnt, g == 1);
        check_b("dbg_gnt", dbg_if.gnt, g == 2);
        check_b("core_stall", core_if.stall, cr && g != 1);
        check_b("dbg_stall", dbg_if.stall, dr && g != 2);
        check_b("mem_MemRW", mem_MemRW, g != 0 && w && al);
        check_w("mem_addr", mem_addr, a);
        check_w("mem_wdata", mem_wdata, wd);
        exp_rd = (g != 0 && !w && al) ? ref_mem[idx(a)] : 32'h0;
        @(posedge clk);
        if (in_rst) begin
            owner = 2; starve = 0;
        end else begin
            if (g != 0 && w && al) ref_mem[idx(a)] = wd;
            starve = (cr && g != 1) ? ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT) : 0;
            owner = g;
        end
        #1;
        check_b("core_rvalid", core_if.rvalid, g == 1);
        check_w("core_rdata", core_if.rdata, (g == 1) ? exp_rd : 32'h0);
        check_b("core_err", core_if.err, g == 1 && !al);
        check_b("dbg_rvalid", dbg_if.rvalid, g == 2);
        check_w("dbg_rdata", dbg_if.rdata, (g == 2) ? exp_rd : 32'h0);
        check_b("dbg_err", dbg_if.err, g == 2 && !al);
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        int          exp_rr [6];
        int          exp_lk [7];
        logic        core_pend, dbg_pend;
        logic [31:0] ra;

        rst_n = 1'b1; dbg_lock = 1'b0;
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);

        // Reset with both requesting, then release: core wins the first tie.
        step();
        step();
        rst_n = 1'b0;
        step();
        check_w("rst_first_grant", last_g, 1);
        check_b("rst_core_rvalid", core_if.rvalid, 1'b1);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);

        // Single-port store then load.
        set_core(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        step();
        check_b("store_committed", dmem[4] === 32'hDEADBEEF, 1'b1);
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        check_w("load_back", core_if.rdata, 32'hDEADBEEF);

        // Round-robin from idle ownership.
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        exp_rr = '{1, 2, 1, 2, 1, 2};
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h14, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_w($sformatf("rr_grant%0d", i), last_g, exp_rr[i]);
        end

        // Lock with starvation escape; wait counter must clear after the core wins.
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        set_dbg(1'b1, 1'b0, 32'h18, 32'h0);
        step();
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        dbg_lock = 1'b1;
        exp_lk = '{2, 2, 2, 2, 1, 2, 2};
        for (int i = 0; i < 7; i++) begin
            step();
            check_w($sformatf("lock_grant%0d", i), last_g, exp_lk[i]);
        end
        dbg_lock = 1'b0;

        // Misaligned debug store over the word at 0x10.
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b1, 1'b1, 32'h13, 32'hFFFFFFFF);
        step();
        check_b("misal_err", dbg_if.err, 1'b1);
        check_b("misal_rvalid", dbg_if.rvalid, 1'b1);
        check_w("misal_mem_kept", dmem[4], 32'hDEADBEEF);

        // Debug write followed immediately by a core read of the same word.
        set_dbg(1'b1, 1'b1, 32'h20, 32'h55);
        step();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        set_core(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        check_w("wr_then_rd", core_if.rdata, 32'h55);

        // Random traffic; requesters hold their transaction until granted.
        core_pend = 1'b0; dbg_pend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!core_pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    ra = 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
                    set_core(1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
                    core_pend = 1'b1;
                end else begin
                    core_if.req = 1'b0;
                end
            end
            if (!dbg_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    ra = 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
                    set_dbg(1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
                    dbg_pend = 1'b1;
                end else begin
                    dbg_if.req = 1'b0;
                end
            end
            dbg_lock = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 99) == 0);
            step();
            if (last_g == 1) core_pend = 1'b0;
            if (last_g == 2) dbg_pend = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (DMEM) between the core's load/store path and a debug/DMA master. Each cycle it grants at most one requester, drives DMEM address, write data and write enable, and returns a registered response one cycle later. It stalls the core whenever the core is not granted, and prevents starvation of either side.

## Interface
- `MAX_WAIT`, 4: number of consecutive denied core-request cycles after which the core wins unconditionally (≥1).
- `ADDR_W`, 32: address width.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-high reset, sampled on `clk`. The `_n` suffix is kept for codebase naming; the signal is active-high.
- `core_req` in 1: core access request.
- `core_we` in 1: 1 = store, 0 = load.
- `core_addr` in ADDR_W: byte address.
- `core_wdata` in 32: store data.
- `core_gnt` out 1: combinational; access accepted this cycle.
- `core_stall` out 1: combinational; `core_req & ~core_gnt`.
- `core_rvalid` out 1: registered response pulse.
- `core_rdata` out 32: registered load data.
- `core_err` out 1: registered misalignment flag.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`, `dbg_err`: same as the `core_` ports, for the debug master.
- `dbg_lock` in 1: debug requests back-to-back ownership.
- `mem_addr` out ADDR_W: to DMEM `address`.
- `mem_wdata` out 32: to DMEM `write_data`.
- `mem_MemRW` out 1: to DMEM `MemRW`; 1 = write.
- `mem_rdata` in 32: from DMEM `read_data`; combinational read.

## Operation
- Owner register `last`, one of IDLE, CORE or DBG: the port granted in the previous cycle. Reset value: DBG, so the core wins the first tie.
- Grant rules, evaluated combinationally each cycle, first match wins:
  1. No requests: no grant; `last` becomes IDLE.
  2. Only one port requesting: grant that port.
  3. Both requesting and `wait_cnt == MAX_WAIT`: grant core.
  4. Both requesting, `dbg_lock` = 1 and `last` = DBG: grant debug.
  5. Both requesting otherwise: round-robin. Grant the port that is not `last`. If `last` = IDLE, grant core.
- `last` is updated to the granted port on each granted cycle.
- `wait_cnt`:
  - Increments, saturating at MAX_WAIT, on each cycle with `core_req` = 1 and `core_gnt` = 0.
  - Clears on any cycle with `core_gnt` = 1 or `core_req` = 0.
  - Reset value: 0.
- Memory drive:
  - `mem_addr` and `mem_wdata` come from the granted port. With no grant they are 0.
  - `mem_MemRW = gnt & we & aligned`, where `aligned = (addr[1:0] == 2'b00)`.
  - A misaligned store is accepted but never written.
- Response, registered at the edge ending the granted cycle:
  - `x_rvalid` = 1 for exactly one cycle.
  - `x_rdata` = `mem_rdata` sampled in the granted cycle for an aligned load, otherwise 0.
  - `x_err` = ~aligned.
- Reset mid-operation: grants are dropped combinationally in the reset cycle; `mem_MemRW` = 0. After the edge, all registers hold their reset values.

## Timing
- Reset values: all `rvalid`, `rdata`, `err` = 0; `wait_cnt` = 0; `last` = DBG. While `rst_n` = 1, `gnt`, `mem_MemRW` and `mem_*` are forced to 0.
- Grant latency: 0 cycles (combinational from `req`). Response latency: exactly 1 cycle after the grant.
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. The arbiter never grants a port whose `req` = 0.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- Worst-case core wait: MAX_WAIT cycles, even under continuous `dbg_lock`.
- A DMEM write commits at the edge ending the granted cycle. A load by the other port in the next cycle sees the new data.

## Test plan
- Reset: hold `rst_n` = 1 with both reqs high → gnts = 0, `mem_MemRW` = 0. Release → core granted first; `core_rvalid` = 1 on the next cycle.
- Single port: core stores 0xDEADBEEF at 0x10 → `mem_MemRW` = 1 for one cycle. Core load of 0x10 → `core_rdata` = 0xDEADBEEF one cycle after its grant.
- Round-robin: both reqs held high for 6 cycles, no lock → grants alternate C, D, C, D, C, D; `core_stall` is high on D cycles.
- Lock and starvation, MAX_WAIT = 4: both reqs high, `dbg_lock` = 1, debug owns the memory → debug is granted 4 more cycles, then core is granted on the 5th; `wait_cnt` returns to 0.
- Misaligned: debug store to 0x13 → `dbg_gnt` = 1, `mem_MemRW` = 0, `dbg_err` = 1, `dbg_rvalid` = 1 next cycle, memory unchanged.
- Write-then-read: debug writes 0x55 to 0x20 in cycle n, core loads 0x20 in cycle n+1 → `core_rdata` = 0x55.
